// File: rtl/dcfifo_stream_reader_if.sv
// FIFO read-port and output-stream signals of the dual-clock FIFO reader.
// The master side is the reader itself; the slave side is the FIFO plus the downstream sink.
interface dcfifo_stream_reader_if #(
    parameter int DW = 8,
    parameter int AW = 10
);
    logic          fifo_read;
    logic          fifo_empty;
    logic [AW-1:0] fifo_data_cnt;
    logic [DW-1:0] fifo_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    modport master (
        output fifo_read, m_valid, m_data,
        input  fifo_empty, fifo_data_cnt, fifo_dout, m_ready
    );

    modport slave (
        input  fifo_read, m_valid, m_data,
        output fifo_empty, fifo_data_cnt, fifo_dout, m_ready
    );
endinterface

// File: rtl/dcfifo_stream_reader.sv
// Read-clock-domain consumer of the dual-clock FIFO: issues reads, captures dout one cycle
// later into a small circular buffer and presents it as a valid/ready stream.
module dcfifo_stream_reader #(
    parameter int DW        = 8,
    parameter int AW        = 10,
    parameter int OUT_DEPTH = 2,
    parameter int CW        = 32,
    localparam int OW       = $clog2(OUT_DEPTH + 1),
    localparam int PW       = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    dcfifo_stream_reader_if.master bus,
    output logic [OW-1:0]         occupancy,
    output logic [AW:0]           backlog,
    output logic [CW-1:0]         drained_cnt
);

    logic [DW-1:0] mem_q [OUT_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] drained_q, drained_d;
    logic          valid;
    logic          pop;
    logic          rd_issue;
    logic [OW:0]   level;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(OUT_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // A slot freed by this cycle's pop may be refilled by a read issued in the same cycle,
    // which is why m_ready reaches fifo_read combinationally.
    always_comb begin
        valid      = (occ_q != '0);
        pop        = valid & bus.m_ready;
        level      = {1'b0, occ_q} + (OW+1)'(inflight_q) - (OW+1)'(pop);
        rd_issue   = en & ~bus.fifo_empty & ~rst & (level < (OW+1)'(OUT_DEPTH));
        inflight_d = rd_issue;
        occ_d      = occ_q + OW'(inflight_q) - OW'(pop);
        wr_ptr_d   = inflight_q ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        drained_d  = drained_q + CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drained_q  <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drained_q  <= drained_d;
        end
    end

    // Capture stage: dout belongs to the read issued last cycle.
    always_ff @(posedge clk) begin
        if (inflight_q) begin
            mem_q[wr_ptr_q] <= bus.fifo_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (({1'b0, occ_q} + (OW+1)'(inflight_q)) <= (OW+1)'(OUT_DEPTH));
            assert (!(rd_issue && bus.fifo_empty));
        end
    end

    assign bus.fifo_read = rd_issue;
    assign bus.m_valid   = valid;
    assign bus.m_data    = valid ? mem_q[rd_ptr_q] : '0;
    assign occupancy     = occ_q;
    assign drained_cnt   = drained_q;
    assign backlog       = (AW+1)'(bus.fifo_data_cnt) + (AW+1)'(occ_q) + (AW+1)'(inflight_q);

endmodule

// File: doc/dcfifo_stream_reader.md
Name: dcfifo_stream_reader

Overview:
- Read-side consumer for the dual-clock FIFO, living entirely in the FIFO read clock domain.
- Drives the FIFO `read` strobe and captures `dout`, which is valid one cycle after `read`.
- Re-presents the data as a valid/ready stream through a small output buffer, so a downstream stall never drops a word and back-to-back throughput is 1 word/cycle.
- Also provides pause control and a drained-word counter for status and debug.

Parameters:
- DW, 8, data width; must match the FIFO DW.
- AW, 10, FIFO address width; sets the width of fifo_data_cnt.
- OUT_DEPTH, 2, output buffer entries; legal range 2..8; must be >= 2 for full throughput.
- CW, 32, width of the drained-word counter.

Ports:
- clk  in  1  FIFO read-domain clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = permitted to issue FIFO reads; 0 = pause. In-flight reads still complete.
- fifo_empty  in  1  FIFO r_empty.
- fifo_data_cnt  in  AW  FIFO r_data_cnt; status pass-through only.
- fifo_read  out  1  FIFO read strobe; one word per asserted cycle.
- fifo_dout  in  DW  FIFO dout; valid the cycle after fifo_read.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- m_data  out  DW  output stream data.
- occupancy  out  $clog2(OUT_DEPTH+1)  words held in the output buffer.
- backlog  out  AW+1  fifo_data_cnt + occupancy + inflight; zero-extended sum.
- drained_cnt  out  CW  total words accepted downstream; wraps modulo 2^CW.

Behaviour:
- Reset, synchronous on posedge clk while rst=1: fifo_read=0, m_valid=0, m_data=0, occupancy=0, drained_cnt=0, inflight=0, buffer pointers=0.
- Reset mid-transfer: an in-flight word and all buffered words are discarded. rst must be asserted together with the FIFO r_rst_n.
- inflight: 1-bit register, = fifo_read of the previous cycle.
- pop = m_valid & m_ready.
- Read issue, combinational: fifo_read = en & ~fifo_empty & ~rst & ((occupancy + inflight - pop) < OUT_DEPTH). The m_ready-to-fifo_read combinational path is intentional.
- Capture: when inflight=1, fifo_dout is written into the buffer at the write pointer that cycle; the write pointer advances modulo OUT_DEPTH.
- Buffer: circular, OUT_DEPTH x DW, with read/write pointers wrapping modulo OUT_DEPTH (non-power-of-two depth is legal).
- Occupancy update: occupancy_next = occupancy + inflight - pop. Simultaneous capture and pop leaves it unchanged.
- Output: m_valid = (occupancy != 0). m_data = buffer[rd_ptr], read combinationally from registered storage; the read pointer advances on pop.
- m_valid/m_data stability: both stay stable while m_valid=1 and m_ready=0.
- No bypass: a captured word appears on m_valid the cycle after capture. Latency from fifo_read to m_valid is 2 cycles.
- Overflow invariant: occupancy + inflight <= OUT_DEPTH at all times; overflow is impossible by construction. A simulation assertion must check this.
- Empty: no read is issued while fifo_empty=1. fifo_empty deasserting lets fifo_read assert in the same cycle.
- en: deasserting en stops new reads immediately. The buffer still drains to the stream.
- drained_cnt: increments by 1 per pop and wraps from 2^CW-1 to 0.
- backlog: combinational sum; fifo_data_cnt lags by the FIFO's synchroniser latency.
- FIFO-side glitches: fifo_read must never assert with fifo_empty=1. m_valid must not toggle while m_ready=0 except from 0 to 1.

Test Plan:
- Reset then preload FIFO with 5 words 0x11..0x15, en=1, m_ready=1 -> fifo_read high for 5 consecutive cycles; m_valid first high 2 cycles after the first read; words 0x11..0x15 on consecutive cycles; drained_cnt=5; occupancy returns to 0.
- Preload 10 words, m_ready=0 -> exactly OUT_DEPTH=2 reads issued then fifo_read stays 0; occupancy=2; m_data=first word, held stable. Raise m_ready -> remaining 8 words stream at 1/cycle with no loss or duplicate.
- Random m_ready (50%) over 1000 words of incrementing data -> output sequence identical and gap-free; occupancy+inflight never exceeds 2; fifo_read never asserted when fifo_empty=1.
- Streaming with en dropped for 4 cycles -> fifo_read low the same cycle en falls; an in-flight word is still captured and delivered; resumes with no loss.
- rst pulsed while occupancy=2 and inflight=1 -> next cycle m_valid=0, occupancy=0, drained_cnt=0, fifo_read=0.
- CW=4, stream 17 words -> drained_cnt reads 15, then 0, then 1 at the end.
